// File: rtl/bus_ctrl_pkg.sv
// Shared types and decode constants for the clocked CPU-board bus controller.
package bus_ctrl_pkg;

    typedef enum logic [2:0] {NONE, ROM, RAML, RAMH, KB, CR, LCD} region_t;

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    // I/O page sub-decode on a[2:1]
    localparam logic [1:0] IO_SEL_KB   = 2'b00;
    localparam logic [1:0] IO_SEL_LCD  = 2'b01;
    localparam logic [1:0] IO_SEL_CR   = 2'b10;
    localparam logic [1:0] IO_SEL_NONE = 2'b11;

endpackage

// File: rtl/bus_ctrl_if.sv
// CPU-side strobes/address/data and the memory/peripheral selects of the bus controller.
interface bus_ctrl_if;
    logic [15:0] a;
    logic        n_oe;
    logic        n_we;
    logic [7:0]  d;
    logic        n_rom_cs;
    logic        n_raml_cs;
    logic        n_ramh_cs;
    logic        n_kb_oe;
    logic        kb_cp;
    logic        lcd_e;
    logic        n_rdy;
    logic [7:0]  cr;
    logic        bus_err;

    modport master (
        output a, n_oe, n_we, d,
        input  n_rom_cs, n_raml_cs, n_ramh_cs, n_kb_oe, kb_cp, lcd_e, n_rdy, cr, bus_err
    );

    modport slave (
        input  a, n_oe, n_we, d,
        output n_rom_cs, n_raml_cs, n_ramh_cs, n_kb_oe, kb_cp, lcd_e, n_rdy, cr, bus_err
    );
endinterface

// File: rtl/bus_ctrl_decode.sv
// Combinational memory-map decode: address and control register to region and active-low selects.
module bus_ctrl_decode
    import bus_ctrl_pkg::*;
#(
    parameter logic [7:0] IO_PAGE = 8'hFF
) (
    input  logic [15:0] i_a,
    input  logic [7:0]  i_cr,
    input  logic        i_n_oe,
    input  logic        i_n_we,
    output region_t     o_region,
    output logic        o_n_rom_cs,
    output logic        o_n_raml_cs,
    output logic        o_n_ramh_cs,
    output logic        o_n_kb_oe,
    output logic        o_kb_cp
);

    logic [2:0] w_bank;
    logic       w_unused;

    assign w_bank   = i_a[14:12];
    assign w_unused = ^{i_a[7:3], i_a[0], i_cr[2:1]};

    always_comb begin
        o_region = NONE;
        if (!i_a[15]) begin
            if (i_cr[0]) o_region = RAML;
            else         o_region = ROM;
        end else if (i_a[15:8] == IO_PAGE) begin
            case (i_a[2:1])
                IO_SEL_KB:   o_region = KB;
                IO_SEL_CR:   o_region = CR;
                IO_SEL_LCD:  o_region = LCD;
                IO_SEL_NONE: o_region = NONE;
            endcase
        end else if (w_bank <= 3'd1) begin
            o_region = RAMH;
        // banks 2..6 are enabled by cr[3..7]; bank 7 is never mapped
        end else if (w_bank != 3'd7 && i_cr[{1'b0, w_bank} + 4'd1]) begin
            o_region = RAMH;
        end
    end

    assign o_n_rom_cs  = (o_region != ROM);
    assign o_n_raml_cs = (o_region != RAML);
    assign o_n_ramh_cs = (o_region != RAMH);
    assign o_n_kb_oe   = ~((o_region == KB) & ~i_n_oe);
    assign o_kb_cp     = ~((o_region == KB) & ~i_n_we);

endmodule

// File: rtl/bus_ctrl.sv
// Clocked bus controller: decode, per-region wait states, LCD enable stretch, control register, bus timeout.
module bus_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int         WS_W    = 4,
    parameter int         ROM_WS  = 2,
    parameter int         RAM_WS  = 0,
    parameter int         IO_WS   = 1,
    parameter int         LCD_WS  = 4,
    parameter int         TIMEOUT = 15,
    parameter logic [7:0] IO_PAGE = 8'hFF
) (
    input  logic     clk,
    input  logic     n_rst,
    bus_ctrl_if.slave bus
);

    if (ROM_WS >= (1 << WS_W) || RAM_WS >= (1 << WS_W) || IO_WS >= (1 << WS_W) ||
        LCD_WS < 1 || (LCD_WS - 1) >= (1 << WS_W) || TIMEOUT >= (1 << WS_W)) begin : g_bad_param
        $error("bus_ctrl: wait-state parameter does not fit WS_W");
    end

    state_t          r_state;
    region_t         r_region;
    logic            r_wr;
    logic [WS_W-1:0] r_cnt;
    logic            r_n_rdy;
    logic            r_lcd_e;
    logic [7:0]      r_cr;
    logic            r_bus_err;

    region_t w_region;
    region_t w_eff_region;
    logic    w_active;
    logic    w_wr;

    bus_ctrl_decode #(.IO_PAGE(IO_PAGE)) u_decode (
        .i_a         (bus.a),
        .i_cr        (r_cr),
        .i_n_oe      (bus.n_oe),
        .i_n_we      (bus.n_we),
        .o_region    (w_region),
        .o_n_rom_cs  (bus.n_rom_cs),
        .o_n_raml_cs (bus.n_raml_cs),
        .o_n_ramh_cs (bus.n_ramh_cs),
        .o_n_kb_oe   (bus.n_kb_oe),
        .o_kb_cp     (bus.kb_cp)
    );

    assign w_active     = ~bus.n_oe | ~bus.n_we;
    assign w_wr         = ~bus.n_we;
    // an LCD read has no target and runs into the timeout
    assign w_eff_region = (w_region == LCD && !w_wr) ? NONE : w_region;

    // LCD loads one less so that lcd_e spans exactly LCD_WS cycles of WAIT
    function automatic logic [WS_W-1:0] ws_of(input region_t r);
        case (r)
            ROM:       ws_of = WS_W'(ROM_WS);
            RAML,RAMH: ws_of = WS_W'(RAM_WS);
            KB, CR:    ws_of = WS_W'(IO_WS);
            LCD:       ws_of = WS_W'(LCD_WS - 1);
            default:   ws_of = WS_W'(TIMEOUT);
        endcase
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_region  <= NONE;
            r_wr      <= 1'b0;
            r_cnt     <= '0;
            r_n_rdy   <= 1'b1;
            r_lcd_e   <= 1'b0;
            r_cr      <= 8'h00;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_n_rdy <= 1'b1;
                    r_lcd_e <= 1'b0;
                    if (w_active) begin
                        r_state  <= WAIT;
                        r_region <= w_eff_region;
                        r_wr     <= w_wr;
                        r_cnt    <= ws_of(w_eff_region);
                        r_lcd_e  <= (w_eff_region == LCD);
                    end
                end
                WAIT: begin
                    if (!w_active) begin
                        r_state <= IDLE;
                        r_lcd_e <= 1'b0;
                        r_n_rdy <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_state <= READY;
                        r_lcd_e <= 1'b0;
                        r_n_rdy <= 1'b0;
                        if (r_region == NONE) begin
                            r_bus_err <= 1'b1;
                        end else if (r_region == CR && r_wr) begin
                            r_cr      <= bus.d;
                            r_bus_err <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                READY: begin
                    if (!w_active) begin
                        r_state <= IDLE;
                        r_n_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_n_rdy <= 1'b1;
                    r_lcd_e <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lcd_e   = r_lcd_e;
    assign bus.n_rdy   = r_n_rdy;
    assign bus.cr      = r_cr;
    assign bus.bus_err = r_bus_err;

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: decode vector table, directed corner sequences, randomized accesses vs. a transaction model.
module tb_bus_ctrl;

    localparam int         WS_W    = 4;
    localparam int         ROM_WS  = 2;
    localparam int         RAM_WS  = 0;
    localparam int         IO_WS   = 1;
    localparam int         LCD_WS  = 4;
    localparam int         TIMEOUT = 15;
    localparam logic [7:0] IO_PAGE = 8'hFF;

    logic clk;
    logic n_rst;
    int   n_chk;
    int   n_fail;

    logic [7:0] m_cr;
    logic       m_err;

    bus_ctrl_if bus ();

    bus_ctrl #(
        .WS_W(WS_W), .ROM_WS(ROM_WS), .RAM_WS(RAM_WS), .IO_WS(IO_WS),
        .LCD_WS(LCD_WS), .TIMEOUT(TIMEOUT), .IO_PAGE(IO_PAGE)
    ) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Region code: 0 none, 1 ROM, 2 RAML, 3 RAMH, 4 KB, 5 CR, 6 LCD
    function automatic void model(input logic [15:0] addr, input logic [7:0] c, input bit wr,
                                  output int rc, output int lat, output bit unm);
        int b;
        rc = 0;
        if (!addr[15]) begin
            rc = c[0] ? 2 : 1;
        end else if (addr[15:8] == IO_PAGE) begin
            case (addr[2:1])
                2'd0:    rc = 4;
                2'd2:    rc = 5;
                2'd1:    rc = 6;
                default: rc = 0;
            endcase
        end else begin
            b = int'(addr[14:12]);
            if (b < 2 || (b < 7 && c[b + 1])) rc = 3;
        end
        unm = (rc == 0) || (rc == 6 && !wr);
        if (unm)                      lat = TIMEOUT + 1;
        else if (rc == 6)             lat = LCD_WS;
        else if (rc == 1)             lat = ROM_WS + 1;
        else if (rc == 2 || rc == 3)  lat = RAM_WS + 1;
        else                          lat = IO_WS + 1;
    endfunction

    // Called at a negedge. hold<0 runs to completion; otherwise release after hold edges (if it aborts).
    task automatic access(input logic [15:0] addr, input bit rd, input bit wr, input logic [7:0] data,
                          input int hold, input logic [15:0] amid);
        int  rc, lat, n, nlcd, h;
        bit  unm;
        model(addr, m_cr, wr, rc, lat, unm);
        bus.a    = addr;
        bus.n_oe = ~rd;
        bus.n_we = ~wr;
        bus.d    = data;
        #1;
        chk("n_rom_cs",  bus.n_rom_cs,  rc != 1);
        chk("n_raml_cs", bus.n_raml_cs, rc != 2);
        chk("n_ramh_cs", bus.n_ramh_cs, rc != 3);
        chk("n_kb_oe",   bus.n_kb_oe,   !(rc == 4 && rd));
        chk("kb_cp",     bus.kb_cp,     !(rc == 4 && wr));
        @(negedge clk);
        bus.a = amid;
        if (hold >= 0 && lat >= 2) begin
            h = hold % lat;
            for (int i = 0; i < h; i++) begin
                chk("rdy_abort_wait", bus.n_rdy, 1'b1);
                @(negedge clk);
            end
            chk("rdy_abort_wait", bus.n_rdy, 1'b1);
        end else begin
            n = 0;
            nlcd = 0;
            while (bus.n_rdy !== 1'b0 && n < lat + 5) begin
                if (bus.lcd_e === 1'b1) nlcd++;
                @(negedge clk);
                n++;
            end
            chk("latency", n, lat);
            chk("lcd_e_cycles", nlcd, (rc == 6 && wr) ? LCD_WS : 0);
            if (rc == 5 && wr) begin
                m_cr  = data;
                m_err = 1'b0;
            end
            if (unm) m_err = 1'b1;
            chk("cr", bus.cr, m_cr);
            chk("bus_err", bus.bus_err, m_err);
            @(negedge clk);
            chk("rdy_hold", bus.n_rdy, 1'b0);
        end
        bus.n_oe = 1'b1;
        bus.n_we = 1'b1;
        @(negedge clk);
        chk("rdy_release", bus.n_rdy, 1'b1);
        chk("lcd_e_idle", bus.lcd_e, 1'b0);
    endtask

    typedef struct {
        logic [7:0]  cr;
        logic [15:0] a;
        bit          rd;
        bit          wr;
        logic [4:0]  sel;   // {n_rom_cs, n_raml_cs, n_ramh_cs, n_kb_oe, kb_cp}
    } vec_t;

    vec_t vecs[15];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        n_rst  = 1'b0;
        bus.a    = 16'h0100;
        bus.n_oe = 1'b1;
        bus.n_we = 1'b1;
        bus.d    = 8'h00;
        m_cr     = 8'h00;
        m_err    = 1'b0;

        vecs[0]  = '{8'h00, 16'h0100, 1, 0, 5'b01111};
        vecs[1]  = '{8'h01, 16'h0100, 1, 0, 5'b10111};
        vecs[2]  = '{8'h00, 16'h8000, 1, 0, 5'b11011};
        vecs[3]  = '{8'h00, 16'h9FFF, 1, 0, 5'b11011};
        vecs[4]  = '{8'h00, 16'hA000, 1, 0, 5'b11111};
        vecs[5]  = '{8'h08, 16'hA000, 1, 0, 5'b11011};
        vecs[6]  = '{8'h80, 16'hE123, 1, 0, 5'b11011};
        vecs[7]  = '{8'h80, 16'hF000, 1, 0, 5'b11111};
        vecs[8]  = '{8'hFE, 16'hF7FF, 1, 0, 5'b11111};
        vecs[9]  = '{8'h00, 16'hFF00, 1, 0, 5'b11101};
        vecs[10] = '{8'h00, 16'hFF00, 0, 1, 5'b11110};
        vecs[11] = '{8'h00, 16'hFF06, 1, 0, 5'b11111};
        vecs[12] = '{8'h04, 16'hC000, 1, 0, 5'b11111};
        vecs[13] = '{8'h20, 16'hC000, 1, 0, 5'b11011};
        vecs[14] = '{8'h01, 16'hFF00, 1, 1, 5'b11100};

        repeat (2) @(negedge clk);
        chk("rst_n_rdy",    bus.n_rdy,    1'b1);
        chk("rst_lcd_e",    bus.lcd_e,    1'b0);
        chk("rst_cr",       bus.cr,       8'h00);
        chk("rst_bus_err",  bus.bus_err,  1'b0);
        chk("rst_n_rom_cs", bus.n_rom_cs, 1'b0);
        n_rst = 1'b1;

        access(16'h0100, 1, 0, 8'h00, -1, 16'h0100);      // ROM: 3 edges
        access(16'hFF04, 0, 1, 8'h09, -1, 16'hFF04);      // CR <- 09
        access(16'h0100, 1, 0, 8'h00, -1, 16'h0100);      // RAML: 1 edge
        access(16'hFF04, 0, 1, 8'h00, -1, 16'hFF04);
        access(16'hA000, 1, 0, 8'h00, -1, 16'hA000);      // unmapped: 16 edges, bus_err
        access(16'hFF04, 0, 1, 8'h00, -1, 16'hFF04);      // clears bus_err
        access(16'hFF02, 0, 1, 8'h55, -1, 16'hFF02);      // LCD write
        access(16'hFF02, 1, 0, 8'h00, -1, 16'hFF02);      // LCD read is unmapped
        access(16'h0100, 1, 0, 8'h00, 1,  16'h0100);      // abort in WAIT
        access(16'h0100, 1, 0, 8'h00, -1, 16'h0100);      // full count again
        access(16'hFF04, 0, 1, 8'h77, 0,  16'hFF04);      // aborted CR write leaves cr alone
        access(16'h0100, 1, 0, 8'h00, -1, 16'h8000);      // address change mid-access
        access(16'hFF04, 1, 1, 8'h3C, -1, 16'hFF04);      // both strobes = write

        for (int t = 0; t < 80; t++) begin
            logic [15:0] ad;
            int          cls, op, hold;
            cls = $urandom_range(0, 5);
            case (cls)
                0:       ad = {1'b0, 15'($urandom)};
                1:       ad = {1'b1, 15'($urandom)};
                2, 3:    ad = {IO_PAGE, 8'($urandom)};
                4:       ad = 16'hFF04;
                default: ad = {1'b1, 3'($urandom_range(2, 6)), 12'($urandom)};
            endcase
            op   = $urandom_range(0, 3);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 100) : -1;
            access(ad, op != 2, op >= 2, 8'($urandom), hold, ad);
        end

        foreach (vecs[i]) begin
            if (m_cr !== vecs[i].cr) access(16'hFF04, 0, 1, vecs[i].cr, -1, 16'hFF04);
            bus.a    = vecs[i].a;
            bus.n_oe = ~vecs[i].rd;
            bus.n_we = ~vecs[i].wr;
            #1;
            chk($sformatf("vec%0d_sel", i),
                {bus.n_rom_cs, bus.n_raml_cs, bus.n_ramh_cs, bus.n_kb_oe, bus.kb_cp}, vecs[i].sel);
            #1;
            bus.n_oe = 1'b1;
            bus.n_we = 1'b1;
            @(negedge clk);
        end

        access(16'hFF04, 0, 1, 8'hA5, -1, 16'hFF04);
        bus.a    = 16'hFF02;
        bus.n_we = 1'b0;
        @(negedge clk);
        chk("lcd_e_in_wait", bus.lcd_e, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_lcd_e",   bus.lcd_e,   1'b0);
        chk("async_rst_n_rdy",   bus.n_rdy,   1'b1);
        chk("async_rst_cr",      bus.cr,      8'h00);
        chk("async_rst_bus_err", bus.bus_err, 1'b0);
        bus.n_we = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        m_cr  = 8'h00;
        m_err = 1'b0;
        access(16'h0100, 1, 0, 8'h00, -1, 16'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Clocked successor to the combinational address decoder / chip-select block of the CPU board. It keeps the same memory map: ROM/RAML, banked RAMH and an I/O page holding the keyboard, control register and LCD. It adds per-region wait-state counting, a stretched LCD enable, an internal control register, and a bus timeout with an error flag. It sits between the CPU bus strobes and the memory/peripheral selects, and drives the CPU's `n_rdy`.

## Interface
Parameters:
- `WS_W`, 4: width of the wait-state counters.
- `ROM_WS`, 2: wait cycles for ROM accesses.
- `RAM_WS`, 0: wait cycles for RAML and RAMH accesses.
- `IO_WS`, 1: wait cycles for keyboard and CR accesses.
- `LCD_WS`, 4: `lcd_e` high time in cycles, ≥1.
- `TIMEOUT`, 15: wait cycles before an unmapped access is terminated, < 2^WS_W.
- `IO_PAGE`, 8'hFF: value of `a[15:8]` that selects the I/O page.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: bus clock.
- `n_rst` in 1: async active-low reset.
- `a` in 16: CPU address.
- `n_oe` in 1: CPU read strobe, active low.
- `n_we` in 1: CPU write strobe, active low.
- `d` in 8: CPU data bus, used for CR writes.
- `n_rom_cs`, `n_raml_cs`, `n_ramh_cs` out 1: memory selects, active low, combinational.
- `n_kb_oe`, `kb_cp` out 1: keyboard read enable and latch clock, combinational.
- `lcd_e` out 1: LCD enable, registered.
- `n_rdy` out 1: ready to CPU; low = ready; registered.
- `cr` out 8: control register.
- `bus_err` out 1: sticky timeout flag.

## Operation
- Decode, combinational from `a` and current `cr`:
  - `a[15]`=0: ROM if `cr[0]`=0, otherwise RAML.
  - `a[15]`=1 and `a[15:8]`≠IO_PAGE: RAMH, with bank b=`a[14:12]`.
    - b∈{0,1} is always selected.
    - b∈{2..6} is selected iff `cr[b+1]`.
    - b=7 and disabled banks are unmapped.
  - I/O page, decoded on `a[2:1]`: 00 = KB, 10 = CR, 01 = LCD, 11 = unmapped.
  - `n_kb_oe` = ~(KB & ~`n_oe`); `kb_cp` = ~(KB & ~`n_we`).
- An access is active when `n_oe`=0 or `n_we`=0.
- FSM states:
  - IDLE → WAIT on the first edge where the access is sampled active. That edge latches the region and loads `cnt` with the region's WS, or TIMEOUT if unmapped.
  - WAIT: decrement `cnt`. Go to READY at the edge where `cnt`=0.
  - READY: hold until the access goes inactive, then go to IDLE.
  - An inactive access sampled in WAIT or READY returns to IDLE and abandons the count.
- Region is latched at access start; address changes mid-access do not change the wait count.
- `n_rdy` is 0 only in READY.
- LCD write: `lcd_e`=1 throughout WAIT and 0 otherwise. An LCD read is unmapped.
- CR write: `cr` ← `d` at the WAIT→READY edge, exactly once per access. Chip selects decode from the new `cr` from that point.
- Timeout: on an unmapped access reaching READY, set `bus_err`. A CR write clears `bus_err` unless that same edge sets it.

## Timing
- Reset values: `cr`=8'h00, `n_rdy`=1, `lcd_e`=0, `bus_err`=0, state IDLE. Reset is effective immediately, including mid-access.
- After reset, `cr`=0 selects ROM at `a[15]`=0.
- Latency: access first sampled at edge k → `n_rdy` low after edge k+WS+1. For WS=0 this is edge k+1.
- `n_rdy` returns high one edge after the access is sampled inactive.
- Counter width: WS values ≥ 2^WS_W are a parameter error (elaboration assertion).
- Simultaneous `n_oe`=0 and `n_we`=0: treat as a write.

## Structure
- `bus_ctrl_pkg` contains:
  - the `region_t` enum: NONE, ROM, RAML, RAMH, KB, CR, LCD;
  - the `state_t` enum: IDLE, WAIT, READY;
  - the decode constants for `a[2:1]`.
- Sub-module `bus_ctrl_decode`: purely combinational `a`/`cr` → `region_t` and the active-low selects. The FSM, counter and registers stay in the top module.

## Test plan
- Reset then a read of 16'h0100 → `n_rom_cs`=0, and `n_rdy` low 3 edges after the access starts (ROM_WS=2).
- Write 8'h09 to 16'hFF04, then read 16'h0100 → `cr`=8'h09, then `n_raml_cs`=0 with `n_rdy` low after 1 edge.
- With `cr`=8'h00, read 16'hA000 (bank 2) → unmapped. `n_rdy` low after 16 edges and `bus_err`=1. A following CR write clears `bus_err`.
- LCD write to 16'hFF02 → `lcd_e` high for 4 cycles, then `n_rdy` low the next edge.
- Strobe released during WAIT of a ROM read → state IDLE, `n_rdy` stays high. The next access restarts the full count.
- `n_rst` pulsed low during an LCD WAIT → `lcd_e`=0, `n_rdy`=1 and `cr`=0 immediately, without waiting for a clock edge.
